cfu_l2_l1_adapter: RTL and testbench
====================================

# cfu_l2_l1_adapter

Adapts a ready/valid handshaked (CFU-L2) requester, such as a CPU or CFU mux port, to a fixed-latency, no-backpressure (CFU-L1) CFU such as the dot-product CFU. It sits directly upstream of the L1 CFU and issues requests into it. It buffers the CFU's responses in a FIFO and uses credit-based admission so the L1 pipeline never needs stalling and never drops a response. Requests and responses stay strictly in order.

## Interface
Parameters:
- CFU_LATENCY, 0: fixed latency N of the downstream L1 CFU, in cycles (≥0).
- CFU_CFU_ID_W, 0: CFU ID width (0 treated as 1 bit, unused).
- CFU_STATE_ID_W, 0: state ID width (0 treated as 1 bit).
- CFU_FUNC_ID_W, $bits(cfid_t): function ID width.
- CFU_DATA_W, 32: data width (32 or 64).
- FIFO_DEPTH, CFU_LATENCY+2: response FIFO entries and credit limit (≥1); ≥N+2 gives full throughput.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock; asynchronous, active-low.
- req_valid / req_ready  in / out  1  upstream request handshake.
- req_cfu, req_state, req_func, req_data0, req_data1  in  respective widths  request fields.
- resp_valid / resp_ready  out / in  1  upstream response handshake.
- resp_status  out  cfu_status_t  response status.
- resp_data  out  CFU_DATA_W  response data.
- cfu_clk_en  out  1  to L1 CFU clk_en; 1 whenever rst_n is high.
- cfu_req_valid  out  1  to L1 CFU; equals the accept strobe (req_valid && req_ready).
- cfu_req_cfu/state/func/data0/data1  out  respective widths  to L1 CFU; combinational pass-through of req_* fields.
- cfu_resp_valid  in  1  from L1 CFU.
- cfu_resp_status  in  cfu_status_t  from L1 CFU.
- cfu_resp_data  in  CFU_DATA_W  from L1 CFU.
- proto_err  out  1  sticky; set when cfu_resp_valid disagrees with the internal tracker.

## Operation
- Accept = req_valid && req_ready. cfu_req_valid = accept in the same cycle; no request register.
- Tracker: an N-stage shift register of valid bits, fed by accept and clocked every cycle. Its output trk (for N=0, trk = accept) marks the cycle in which the L1 response is due.
- Push: when trk=1, {cfu_resp_status, cfu_resp_data} is written to the FIFO tail. cfu_resp_valid is never used to gate the push.
- Pop: resp_valid && resp_ready.
- resp_valid = FIFO non-empty. resp_status and resp_data come from the FIFO head and are registered (flop or LUT-RAM read plus flop), never combinational from cfu_resp_*.
- Credit counter cnt, range 0..FIFO_DEPTH, counts in-flight requests plus FIFO occupancy.
  - cnt_next = cnt + accept − pop.
  - req_ready = (cnt < FIFO_DEPTH) && rst_n high. It depends only on registered cnt, with no combinational path from resp_ready.
- Overflow is impossible: a push always has a credit reserved. Push and pop in the same cycle are legal at any occupancy, including full and empty-with-push.
- Pointers wrap modulo FIFO_DEPTH; non-power-of-2 depths are legal.
- proto_err is set (sticky until reset) when cfu_resp_valid != trk in any cycle. Data is still pushed per trk.
- The req_cfu field is forwarded only; the adapter does not decode it.
- Reset (rst_n low, asynchronous) clears:
  - cnt, tracker bits, FIFO pointers and proto_err;
  - resp_valid=0, req_ready=0, cfu_req_valid=0, cfu_clk_en=0.
  - resp_data and resp_status have no reset requirement.
- Reset mid-operation: in-flight and buffered responses are discarded. L1 responses arriving after deassertion for pre-reset requests are not pushed, because the tracker was cleared. proto_err is suppressed for the first N cycles after deassertion.

## Timing
- Request accepted at edge of cycle t → L1 sees it in cycle t → L1 response in cycle t+N → pushed at end of t+N → resp_valid in cycle t+N+1.
- Minimum accept-to-response latency is N+1 cycles; N=0 gives t+1.
- Throughput is 1 request/cycle sustained when FIFO_DEPTH ≥ N+2 and resp_ready=1. Smaller depths throttle via req_ready.
- A freed credit shows on req_ready the cycle after the pop.
- After rst_n deasserts, req_ready=1 in the first cycle (cnt=0).

## Test plan
- Single request, N=2, DEPTH=4, dotprod function 0, data0=0x01020304, data1=0x01010101 (ELEM_W=8) → resp_valid exactly at t+3, resp_data=10, status CFU_OK, proto_err=0.
- 8 back-to-back requests, N=2, DEPTH=4, resp_ready=1 → req_ready stays 1 throughout; 8 responses on consecutive cycles, in order, data matching a reference model.
- resp_ready=0, N=2, DEPTH=4 → exactly 4 requests accepted, then req_ready=0. Raise resp_ready → 4 in-order responses; req_ready=1 the cycle after the first pop.
- Reset pulse mid-flight (2 in flight, 1 buffered) → resp_valid and req_ready go 0 asynchronously. After deassert: no stale responses appear, cnt=0, req_ready=1, proto_err=0.
- Invalid function 5 → resp_status=CFU_ERROR_FUNC, passed through unchanged and in order with neighbouring OK responses.
- N=0, DEPTH=1 → every request yields resp_valid at t+1; throughput is 1 request per 2 cycles. Forcing a spurious cfu_resp_valid → proto_err=1, remaining set until reset.

Source files
------------

// File: rtl/cfu_l2_l1_adapter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cfu_l2_l1_adapter_if : CFU types and the CFU-L2 request/response bundle  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

package cfu_pkg;
  typedef logic [9:0] cfid_t;

  typedef enum logic [2:0] {
    CFU_OK           = 3'd0,
    CFU_ERROR_CFU    = 3'd1,
    CFU_ERROR_OFF    = 3'd2,
    CFU_ERROR_STATE  = 3'd3,
    CFU_ERROR_FUNC   = 3'd4,
    CFU_ERROR_OP     = 3'd5,
    CFU_ERROR_CUSTOM = 3'd6
  } cfu_status_t;
endpackage

interface cfu_l2_l1_adapter_if #(
  parameter int CFU_ID_W   = 1,
  parameter int STATE_ID_W = 1,
  parameter int FUNC_ID_W  = 10,
  parameter int DATA_W     = 32
);
  import cfu_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [CFU_ID_W-1:0]   req_cfu;
  logic [STATE_ID_W-1:0] req_state;
  logic [FUNC_ID_W-1:0]  req_func;
  logic [DATA_W-1:0]     req_data0;
  logic [DATA_W-1:0]     req_data1;

  logic                  resp_valid;
  logic                  resp_ready;
  cfu_status_t           resp_status;
  logic [DATA_W-1:0]     resp_data;

  modport master (
    output req_valid, req_cfu, req_state, req_func, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_cfu, req_state, req_func, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_status, resp_data
  );
endinterface

`default_nettype wire

// File: rtl/cfu_l2_l1_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cfu_l2_l1_adapter : ready/valid CFU-L2 port onto a fixed-latency L1 CFU  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module cfu_l2_l1_adapter
  import cfu_pkg::*;
#(
  parameter int CFU_LATENCY    = 0,
  parameter int CFU_CFU_ID_W   = 0,
  parameter int CFU_STATE_ID_W = 0,
  parameter int CFU_FUNC_ID_W  = $bits(cfid_t),
  parameter int CFU_DATA_W     = 32,
  parameter int FIFO_DEPTH     = CFU_LATENCY + 2,
  localparam int CID_W = (CFU_CFU_ID_W   == 0) ? 1 : CFU_CFU_ID_W,
  localparam int SID_W = (CFU_STATE_ID_W == 0) ? 1 : CFU_STATE_ID_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cfu_l2_l1_adapter_if.slave       l2,

  output logic                     cfu_clk_en,
  output logic                     cfu_req_valid,
  output logic [CID_W-1:0]         cfu_req_cfu,
  output logic [SID_W-1:0]         cfu_req_state,
  output logic [CFU_FUNC_ID_W-1:0] cfu_req_func,
  output logic [CFU_DATA_W-1:0]    cfu_req_data0,
  output logic [CFU_DATA_W-1:0]    cfu_req_data1,
  input  logic                     cfu_resp_valid,
  input  cfu_status_t              cfu_resp_status,
  input  logic [CFU_DATA_W-1:0]    cfu_resp_data,

  output logic                     proto_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SW = $bits(cfu_status_t);
  localparam int EW = SW + CFU_DATA_W;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  logic          ready;
  logic          accept;
  logic          pop;
  logic          trk;
  logic          sup_ok;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic          proto_err_q, proto_err_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credits cover in-flight requests as well as stored responses, so every push has a slot.
  assign ready  = rst_n && (cnt_q < DEPTH_C);
  assign accept = l2.req_valid && ready;
  assign pop    = (occ_q != '0) && l2.resp_ready;

  assign l2.req_ready   = ready;
  assign l2.resp_valid  = (occ_q != '0);
  assign head           = mem_q[rd_q];
  assign l2.resp_status = cfu_status_t'(head[EW-1 -: SW]);
  assign l2.resp_data   = head[CFU_DATA_W-1:0];

  assign cfu_clk_en    = rst_n;
  assign cfu_req_valid = accept;
  assign cfu_req_cfu   = l2.req_cfu;
  assign cfu_req_state = l2.req_state;
  assign cfu_req_func  = l2.req_func;
  assign cfu_req_data0 = l2.req_data0;
  assign cfu_req_data1 = l2.req_data1;
  assign proto_err     = proto_err_q;

  generate
    if (CFU_LATENCY == 0) begin : g_trk_comb
      assign trk = accept;
    end else begin : g_trk_pipe
      logic [CFU_LATENCY-1:0] trk_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trk_q <= '0;
        else        trk_q <= (trk_q << 1) | CFU_LATENCY'(accept);
      end
      assign trk = trk_q[CFU_LATENCY-1];
    end
  endgenerate

  // L1 responses to pre-reset requests may still emerge during the first N cycles.
  generate
    if (CFU_LATENCY == 0) begin : g_sup_none
      assign sup_ok = 1'b1;
    end else begin : g_sup_cnt
      localparam int UW = $clog2(CFU_LATENCY + 1);
      logic [UW-1:0] sup_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             sup_q <= UW'(CFU_LATENCY);
        else if (sup_q != '0)   sup_q <= sup_q - 1'b1;
      end
      assign sup_ok = (sup_q == '0);
    end
  endgenerate

  always_comb begin
    cnt_d       = cnt_q + CW'(accept) - CW'(pop);
    occ_d       = occ_q + CW'(trk) - CW'(pop);
    wr_d        = trk ? ptr_inc(wr_q) : wr_q;
    rd_d        = pop ? ptr_inc(rd_q) : rd_q;
    proto_err_d = proto_err_q || (sup_ok && (cfu_resp_valid != trk));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      occ_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      occ_q       <= occ_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (trk) mem_q[wr_q] <= {cfu_resp_status, cfu_resp_data};
  end

endmodule

`default_nettype wire

// File: tb/tb_cfu_l2_l1_adapter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cfu_l2_l1_adapter : bench for two adapter configs with dot-product L1 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_cfu_l2_l1_adapter;
  import cfu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dot4(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s = '0;
    for (int i = 0; i < 4; i++) s += 32'(a[8*i +: 8]) * 32'(b[8*i +: 8]);
    return s;
  endfunction

  function automatic cfu_status_t l1_status(input logic [9:0] f);
    return (f == 10'd0) ? CFU_OK : CFU_ERROR_FUNC;
  endfunction

  function automatic logic [31:0] l1_data(input logic [9:0] f, input logic [31:0] a, input logic [31:0] b);
    return (f == 10'd0) ? dot4(a, b) : 32'd0;
  endfunction

  // ---------------- DUT A: N=2, DEPTH=4 ----------------
  cfu_l2_l1_adapter_if a_if ();
  logic        a_clk_en, a_cvalid, a_rvalid, a_perr;
  logic [0:0]  a_ccfu, a_cstate;
  logic [9:0]  a_cfunc;
  logic [31:0] a_cd0, a_cd1, a_rdata;
  cfu_status_t a_rstat;

  cfu_l2_l1_adapter #(.CFU_LATENCY(2), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .l2(a_if),
    .cfu_clk_en(a_clk_en), .cfu_req_valid(a_cvalid), .cfu_req_cfu(a_ccfu),
    .cfu_req_state(a_cstate), .cfu_req_func(a_cfunc), .cfu_req_data0(a_cd0),
    .cfu_req_data1(a_cd1), .cfu_resp_valid(a_rvalid), .cfu_resp_status(a_rstat),
    .cfu_resp_data(a_rdata), .proto_err(a_perr)
  );

  // Two-stage L1 dot-product unit; it holds its pipeline while clk_en is low.
  logic        pa_v0 = 1'b0, pa_v1 = 1'b0;
  cfu_status_t pa_s0, pa_s1;
  logic [31:0] pa_d0, pa_d1;
  always @(posedge clk) begin
    if (a_clk_en) begin
      pa_v0 <= a_cvalid;
      pa_s0 <= l1_status(a_cfunc);
      pa_d0 <= l1_data(a_cfunc, a_cd0, a_cd1);
      pa_v1 <= pa_v0;
      pa_s1 <= pa_s0;
      pa_d1 <= pa_d0;
    end
  end
  assign a_rvalid = pa_v1;
  assign a_rstat  = pa_s1;
  assign a_rdata  = pa_d1;

  // ---------------- DUT B: N=0, DEPTH=1 ----------------
  cfu_l2_l1_adapter_if b_if ();
  logic        b_clk_en, b_cvalid, b_rvalid, b_perr;
  logic        b_spur = 1'b0;
  logic [0:0]  b_ccfu, b_cstate;
  logic [9:0]  b_cfunc;
  logic [31:0] b_cd0, b_cd1, b_rdata;
  cfu_status_t b_rstat;

  cfu_l2_l1_adapter #(.CFU_LATENCY(0), .FIFO_DEPTH(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .l2(b_if),
    .cfu_clk_en(b_clk_en), .cfu_req_valid(b_cvalid), .cfu_req_cfu(b_ccfu),
    .cfu_req_state(b_cstate), .cfu_req_func(b_cfunc), .cfu_req_data0(b_cd0),
    .cfu_req_data1(b_cd1), .cfu_resp_valid(b_rvalid), .cfu_resp_status(b_rstat),
    .cfu_resp_data(b_rdata), .proto_err(b_perr)
  );

  assign b_rvalid = b_cvalid | b_spur;
  assign b_rstat  = l1_status(b_cfunc);
  assign b_rdata  = l1_data(b_cfunc, b_cd0, b_cd1);

  // ---------------- reference model: in-order response queues ----------------
  cfu_status_t a_exp_s[$], b_exp_s[$];
  logic [31:0] a_exp_d[$], b_exp_d[$];
  int          a_pop_cyc[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      a_exp_s.delete(); a_exp_d.delete();
    end else begin
      if (a_if.req_valid && a_if.req_ready) begin
        a_exp_s.push_back(l1_status(a_if.req_func));
        a_exp_d.push_back(l1_data(a_if.req_func, a_if.req_data0, a_if.req_data1));
      end
      if (a_if.resp_valid && a_if.resp_ready) begin
        if (a_exp_s.size() == 0) chk_eq("a_unexpected_resp", 1, 0);
        else begin
          chk_eq("a_resp_status", 64'(a_if.resp_status), 64'(a_exp_s[0]));
          chk_eq("a_resp_data", a_if.resp_data, a_exp_d[0]);
          void'(a_exp_s.pop_front()); void'(a_exp_d.pop_front());
          a_pop_cyc.push_back(cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_exp_s.delete(); b_exp_d.delete();
    end else begin
      if (b_if.req_valid && b_if.req_ready) begin
        b_exp_s.push_back(l1_status(b_if.req_func));
        b_exp_d.push_back(l1_data(b_if.req_func, b_if.req_data0, b_if.req_data1));
      end
      if (b_if.resp_valid && b_if.resp_ready) begin
        if (b_exp_s.size() == 0) chk_eq("b_unexpected_resp", 1, 0);
        else begin
          chk_eq("b_resp_status", 64'(b_if.resp_status), 64'(b_exp_s[0]));
          chk_eq("b_resp_data", b_if.resp_data, b_exp_d[0]);
          void'(b_exp_s.pop_front()); void'(b_exp_d.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic a_send(input logic [9:0] f, input logic [31:0] d0, input logic [31:0] d1, output int waited);
    logic acc = 1'b0;
    waited = 0;
    a_if.req_valid = 1'b1; a_if.req_func = f; a_if.req_data0 = d0; a_if.req_data1 = d1;
    a_if.req_cfu = 1'($urandom); a_if.req_state = 1'($urandom);
    while (!acc && waited < 100) begin
      @(negedge clk); acc = a_if.req_ready;
      @(posedge clk); waited++;
    end
    if (!acc) chk_eq("a_send_timeout", 0, 1);
    #1 a_if.req_valid = 1'b0;
  endtask

  task automatic b_send(input logic [9:0] f, input logic [31:0] d0, input logic [31:0] d1, output int waited);
    logic acc = 1'b0;
    waited = 0;
    b_if.req_valid = 1'b1; b_if.req_func = f; b_if.req_data0 = d0; b_if.req_data1 = d1;
    b_if.req_cfu = 1'($urandom); b_if.req_state = 1'($urandom);
    while (!acc && waited < 100) begin
      @(negedge clk); acc = b_if.req_ready;
      @(posedge clk); waited++;
    end
    if (!acc) chk_eq("b_send_timeout", 0, 1);
    #1 b_if.req_valid = 1'b0;
  endtask

  task automatic a_rand_fields();
    a_if.req_cfu   = 1'($urandom);
    a_if.req_state = 1'($urandom);
    a_if.req_func  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1, 7)) : 10'd0;
    a_if.req_data0 = $urandom;
    a_if.req_data1 = $urandom;
  endtask

  task automatic a_drain(input string tag);
    int n = 0;
    a_if.req_valid = 1'b0; a_if.resp_ready = 1'b1;
    while ((a_exp_s.size() != 0 || a_if.resp_valid) && n < 64) begin
      @(negedge clk); n++;
    end
    chk_eq(tag, a_exp_s.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic b_drain(input string tag);
    int n = 0;
    b_if.req_valid = 1'b0; b_if.resp_ready = 1'b1;
    while ((b_exp_s.size() != 0 || b_if.resp_valid) && n < 64) begin
      @(negedge clk); n++;
    end
    chk_eq(tag, b_exp_s.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int w, acc, seen, p0, p7;
    logic got;

    a_if.req_valid = 1'b1; a_if.req_cfu = '0; a_if.req_state = '0; a_if.req_func = '0;
    a_if.req_data0 = '0; a_if.req_data1 = '0; a_if.resp_ready = 1'b1;
    b_if.req_valid = 1'b0; b_if.req_cfu = '0; b_if.req_state = '0; b_if.req_func = '0;
    b_if.req_data0 = '0; b_if.req_data1 = '0; b_if.resp_ready = 1'b1;

    // Reset state, with a request held valid to show it is blocked.
    #3;
    chk_eq("a_rst_resp_valid", a_if.resp_valid, 0);
    chk_eq("a_rst_req_ready", a_if.req_ready, 0);
    chk_eq("a_rst_cfu_req_valid", a_cvalid, 0);
    chk_eq("a_rst_clk_en", a_clk_en, 0);
    chk_eq("a_rst_proto_err", a_perr, 0);
    chk_eq("b_rst_req_ready", b_if.req_ready, 0);
    a_if.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk_eq("a_ready_first_cycle", a_if.req_ready, 1);
    chk_eq("a_clk_en_run", a_clk_en, 1);
    @(posedge clk); #1;

    // Single dot-product request: 1*1+2*1+3*1+4*1 = 10, visible exactly at t+3.
    a_if.req_valid = 1'b1; a_if.req_func = 10'd0; a_if.req_cfu = 1'b1; a_if.req_state = 1'b1;
    a_if.req_data0 = 32'h0102_0304; a_if.req_data1 = 32'h0101_0101;
    @(negedge clk);
    chk_eq("a_cfu_req_valid", a_cvalid, 1);
    chk_eq("a_cfu_req_data0", a_cd0, 32'h0102_0304);
    chk_eq("a_cfu_req_data1", a_cd1, 32'h0101_0101);
    chk_eq("a_cfu_req_cfu", a_ccfu, 1);
    chk_eq("a_cfu_req_state", a_cstate, 1);
    @(posedge clk); #1 a_if.req_valid = 1'b0;
    @(negedge clk); chk_eq("a_single_t1", a_if.resp_valid, 0);
    @(negedge clk); chk_eq("a_single_t2", a_if.resp_valid, 0);
    @(negedge clk);
    chk_eq("a_single_t3_valid", a_if.resp_valid, 1);
    chk_eq("a_single_data", a_if.resp_data, 32'd10);
    chk_eq("a_single_status", 64'(a_if.resp_status), 64'(CFU_OK));
    chk_eq("a_single_proto_err", a_perr, 0);
    @(posedge clk); #1;
    a_drain("a_drain_single");

    // Eight back-to-back requests at full throughput.
    a_pop_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      a_send(10'd0, $urandom, $urandom, w);
      chk_eq("a_b2b_ready", w, 1);
    end
    a_drain("a_drain_b2b");
    chk_eq("a_b2b_count", a_pop_cyc.size(), 8);
    p0 = (a_pop_cyc.size() > 0) ? a_pop_cyc[0] : 0;
    p7 = (a_pop_cyc.size() > 7) ? a_pop_cyc[7] : 0;
    chk_eq("a_b2b_consecutive", p7 - p0, 7);

    // Backpressure: four credits, then blocked until a pop frees one.
    a_if.resp_ready = 1'b0; acc = 0;
    a_rand_fields(); a_if.req_valid = 1'b1;
    repeat (8) begin
      @(negedge clk); got = a_if.req_ready; acc += int'(got);
      @(posedge clk); #1;
      if (got) a_rand_fields();
    end
    a_if.req_valid = 1'b0;
    chk_eq("a_bp_accepted", acc, 4);
    chk_eq("a_bp_ready_low", a_if.req_ready, 0);
    a_if.resp_ready = 1'b1;
    @(negedge clk);
    chk_eq("a_bp_ready_at_pop", a_if.req_ready, 0);
    chk_eq("a_bp_valid_at_pop", a_if.resp_valid, 1);
    @(negedge clk);
    chk_eq("a_bp_ready_after_pop", a_if.req_ready, 1);
    @(posedge clk); #1;
    a_drain("a_drain_bp");

    // Reset pulse with one buffered and two in flight.
    a_if.resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) a_send(10'd0, $urandom, $urandom, w);
    chk_eq("a_pre_rst_valid", a_if.resp_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("a_rst_async_valid", a_if.resp_valid, 0);
    chk_eq("a_rst_async_ready", a_if.req_ready, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    a_if.resp_ready = 1'b1;
    @(negedge clk);
    chk_eq("a_ready_after_rst", a_if.req_ready, 1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_if.resp_valid) seen++;
    end
    chk_eq("a_no_stale_resp", seen, 0);
    chk_eq("a_proto_err_after_rst", a_perr, 0);
    @(posedge clk); #1;

    // Invalid function among OK neighbours.
    a_send(10'd0, 32'h0505_0505, 32'h0202_0202, w);
    a_send(10'd5, 32'hdead_beef, 32'h1234_5678, w);
    a_send(10'd0, 32'hff00_ff00, 32'h0101_0101, w);
    a_drain("a_drain_func");

    // Random traffic with random backpressure.
    a_rand_fields(); a_if.req_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); got = a_if.req_valid && a_if.req_ready;
      @(posedge clk); #1;
      a_if.resp_ready = ($urandom_range(0, 9) < 6);
      if (!a_if.req_valid || got) begin
        a_if.req_valid = ($urandom_range(0, 9) < 7);
        a_rand_fields();
      end
    end
    a_drain("a_drain_random");
    chk_eq("a_proto_err_final", a_perr, 0);

    // DUT B: zero latency, single-entry FIFO.
    b_send(10'd0, 32'h0102_0304, 32'h0101_0101, w);
    chk_eq("b_cfu_req_func", b_cfunc, b_if.req_func);
    chk_eq("b_cfu_req_cfu", b_ccfu, b_if.req_cfu);
    chk_eq("b_cfu_req_state", b_cstate, b_if.req_state);
    @(negedge clk);
    chk_eq("b_lat_t1_first", b_if.resp_valid, 1);
    chk_eq("b_first_data", b_if.resp_data, 32'd10);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      b_send(($urandom_range(0, 1) == 0) ? 10'd0 : 10'd5, $urandom, $urandom, w);
      @(negedge clk); chk_eq("b_lat_t1", b_if.resp_valid, 1);
      @(posedge clk); #1;
    end
    b_drain("b_drain_single");

    acc = 0;
    b_if.req_valid = 1'b1; b_if.req_func = 10'd0;
    b_if.req_data0 = $urandom; b_if.req_data1 = $urandom;
    repeat (10) begin
      @(negedge clk); got = b_if.req_ready; acc += int'(got);
      @(posedge clk); #1;
      if (got) begin b_if.req_data0 = $urandom; b_if.req_data1 = $urandom; end
    end
    b_if.req_valid = 1'b0;
    chk_eq("b_throughput", acc, 5);
    b_drain("b_drain_tput");

    // Spurious L1 response sets a sticky protocol error.
    chk_eq("b_proto_err_pre", b_perr, 0);
    b_spur = 1'b1;
    @(posedge clk); #1 b_spur = 1'b0;
    @(negedge clk);
    chk_eq("b_proto_err_set", b_perr, 1);
    chk_eq("b_spur_no_resp", b_if.resp_valid, 0);
    repeat (5) @(negedge clk);
    chk_eq("b_proto_err_sticky", b_perr, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk_eq("b_proto_err_rst", b_perr, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_eq("b_proto_err_after_rst", b_perr, 0);
    chk_eq("a_proto_err_end", a_perr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
